// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers pixel position from h_sync/v_sync and measures
// line/frame timing, declaring lock once it matches the configured mode.
module vga_sync_monitor #(
    parameter bit H_SYNC_POL  = 1'b0,
    parameter bit V_SYNC_POL  = 1'b0,
    parameter int H_TOTAL     = 1328,
    parameter int H_SYNC      = 136,
    parameter int H_SYNC_BP   = 280,
    parameter int H_VIZ       = 1024,
    parameter int V_TOTAL     = 806,
    parameter int V_SYNC      = 6,
    parameter int V_SYNC_BP   = 35,
    parameter int V_VIZ       = 768,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic [10:0] px_x,
    output logic [10:0] px_y,
    output logic        visible,
    output logic [10:0] line_len,
    output logic [10:0] hsync_len,
    output logic [10:0] frame_lines,
    output logic [10:0] vsync_lines,
    output logic        locked,
    output logic        err
);

    localparam int GW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0]   CMAX = 11'h7ff;
    localparam logic [10:0]   HT   = 11'(H_TOTAL);
    localparam logic [10:0]   HS   = 11'(H_SYNC);
    localparam logic [10:0]   HBP  = 11'(H_SYNC_BP);
    localparam logic [10:0]   HEND = 11'(H_SYNC_BP + H_VIZ);
    localparam logic [10:0]   VT   = 11'(V_TOTAL);
    localparam logic [10:0]   VS   = 11'(V_SYNC);
    localparam logic [10:0]   VBP  = 11'(V_SYNC_BP);
    localparam logic [10:0]   VEND = 11'(V_SYNC_BP + V_VIZ);
    localparam logic [GW-1:0] LF   = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t state, state_n;

    logic          hs_q, vs_q;
    logic          hs_act, vs_act;
    logic          h_lead, h_trail, v_lead, v_trail;
    logic [10:0]   h_cnt, v_cnt, vs_cnt;
    logic [10:0]   h_inc, v_cnt_n, vs_cnt_n;
    logic          v_pend, v_pend_n;
    logic          line_fail;
    logic          fb, line_ok, line_bad, frame_ok, tmo;
    logic [GW-1:0] good, good_n;
    logic          err_d;
    logic          in_h, in_v;

    assign hs_act  = (h_sync == H_SYNC_POL);
    assign vs_act  = (v_sync == V_SYNC_POL);
    assign h_lead  = hs_act && (hs_q != H_SYNC_POL);
    assign h_trail = !hs_act && (hs_q == H_SYNC_POL);
    assign v_lead  = vs_act && (vs_q != V_SYNC_POL);
    assign v_trail = !vs_act && (vs_q == V_SYNC_POL);

    assign h_inc    = (h_cnt == CMAX) ? CMAX : h_cnt + 11'd1;
    assign fb       = h_lead && (v_pend || v_lead);
    assign line_ok  = (h_cnt + 11'd1 == HT) && (hsync_len == HS);
    assign line_bad = h_lead && !line_ok;
    assign frame_ok = (v_cnt + 11'd1 == VT) && (vsync_lines == VS)
                      && !line_fail && line_ok;
    assign tmo      = (h_cnt == CMAX) || (v_cnt == CMAX);

    // Vertical counters advance only on line starts; a pending v_lead
    // turns the next line start into a frame boundary.
    always_comb begin
        v_cnt_n  = v_cnt;
        vs_cnt_n = vs_cnt;
        v_pend_n = v_pend || v_lead;
        if (h_lead) begin
            if (v_pend || v_lead) begin
                v_cnt_n  = '0;
                vs_cnt_n = 11'd1;
                v_pend_n = 1'b0;
            end else begin
                v_cnt_n = (v_cnt == CMAX) ? CMAX : v_cnt + 11'd1;
                if (vs_act && vs_cnt != CMAX)
                    vs_cnt_n = vs_cnt + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q        <= ~H_SYNC_POL;
            vs_q        <= ~V_SYNC_POL;
            h_cnt       <= '0;
            v_cnt       <= '0;
            vs_cnt      <= '0;
            v_pend      <= 1'b0;
            line_fail   <= 1'b0;
            line_len    <= '0;
            hsync_len   <= '0;
            frame_lines <= '0;
            vsync_lines <= '0;
        end else begin
            hs_q      <= h_sync;
            vs_q      <= v_sync;
            h_cnt     <= h_lead ? 11'd0 : h_inc;
            v_cnt     <= v_cnt_n;
            vs_cnt    <= vs_cnt_n;
            v_pend    <= v_pend_n;
            line_fail <= fb ? 1'b0 : (line_fail || line_bad);
            if (h_lead)
                line_len <= h_cnt + 11'd1;
            if (h_trail)
                hsync_len <= h_cnt + 11'd1;
            if (fb)
                frame_lines <= v_cnt + 11'd1;
            if (v_trail)
                vsync_lines <= vs_cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_SEARCH;
            good  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            good  <= good_n;
            err   <= err_d;
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good;
        unique case (state)
            S_SEARCH: begin
                if (fb) begin
                    state_n = S_TRACK;
                    good_n  = '0;
                end
            end
            S_TRACK: begin
                if (fb) begin
                    if (frame_ok) begin
                        good_n = good + GW'(1);
                        if (good_n == LF)
                            state_n = S_LOCKED;
                    end else begin
                        good_n = '0;
                    end
                end
            end
            S_LOCKED: begin
                if (line_bad || (fb && !frame_ok)) begin
                    state_n = S_TRACK;
                    good_n  = '0;
                end
            end
            default: begin
                state_n = S_SEARCH;
                good_n  = '0;
            end
        endcase
        // A stalled counter means the sync source is gone
        if (tmo) begin
            state_n = S_SEARCH;
            good_n  = '0;
        end
    end

    always_comb begin
        locked  = (state == S_LOCKED);
        err_d   = locked && (state_n != S_LOCKED);
        in_h    = (h_cnt >= HBP) && (h_cnt < HEND);
        in_v    = (v_cnt >= VBP) && (v_cnt < VEND);
        visible = locked && in_h && in_v;
        px_x    = visible ? h_cnt - HBP : 11'd0;
        px_y    = visible ? v_cnt - VBP : 11'd0;
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down video mode
// so that several whole frames fit in a short run.
module tb_vga_sync_monitor;

    localparam int HT  = 64;
    localparam int HS  = 8;
    localparam int HBP = 20;
    localparam int HV  = 40;
    localparam int VT  = 16;
    localparam int VS  = 3;
    localparam int VBP = 5;
    localparam int VV  = 10;

    logic        clk;
    logic        rst_n;
    logic        h_sync;
    logic        v_sync;
    logic [10:0] px_x, px_y;
    logic        visible;
    logic [10:0] line_len, hsync_len, frame_lines, vsync_lines;
    logic        locked;
    logic        err;

    int gl, gi, pl, pc, vsl, short_l;
    int passed, total;
    int first_err, err_cnt;

    vga_sync_monitor #(
        .H_SYNC_POL (1'b0),
        .V_SYNC_POL (1'b0),
        .H_TOTAL    (HT),
        .H_SYNC     (HS),
        .H_SYNC_BP  (HBP),
        .H_VIZ      (HV),
        .V_TOTAL    (VT),
        .V_SYNC     (VS),
        .V_SYNC_BP  (VBP),
        .V_VIZ      (VV),
        .LOCK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .px_x       (px_x),
        .px_y       (px_y),
        .visible    (visible),
        .line_len   (line_len),
        .hsync_len  (hsync_len),
        .frame_lines(frame_lines),
        .vsync_lines(vsync_lines),
        .locked     (locked),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock of the reference generator at position (gl, gi).
    task automatic step();
        int hl;
        h_sync = (gi < HS) ? 1'b0 : 1'b1;
        v_sync = (gl < vsl) ? 1'b0 : 1'b1;
        pl = gl;
        pc = gi;
        @(posedge clk);
        #1;
        hl = (gl == short_l) ? HT - 1 : HT;
        gi++;
        if (gi >= hl) begin
            gi = 0;
            gl = (gl + 1) % VT;
        end
    endtask

    // Advance until position (l, c) has just been clocked in.
    task automatic run_to(input int l, input int c);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(pl == l && pc == c) && n < 5000);
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        gl      = 0;
        gi      = 0;
        pl      = 0;
        pc      = 0;
        vsl     = VS;
        short_l = -1;
        rst_n   = 1'b0;
        h_sync  = 1'b1;
        v_sync  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_line_len", 32'(line_len), 0);
        chk("rst_visible", 32'(visible), 0);
        rst_n = 1'b1;

        // nominal timing: lock at the third frame boundary
        step();
        chk("b1_locked", 32'(locked), 0);
        run_to(0, 0);
        chk("b2_locked", 32'(locked), 0);
        chk("line_len", 32'(line_len), HT);
        chk("hsync_len", 32'(hsync_len), HS);
        chk("frame_lines", 32'(frame_lines), VT);
        chk("vsync_lines", 32'(vsync_lines), VS);
        run_to(0, 0);
        chk("b3_locked", 32'(locked), 1);
        chk("b3_err", 32'(err), 0);

        // visible window edges
        run_to(VBP, HBP - 1);
        chk("pre_vis", 32'(visible), 0);
        run_to(VBP, HBP);
        chk("first_vis", 32'(visible), 1);
        chk("first_px_x", 32'(px_x), 0);
        chk("first_px_y", 32'(px_y), 0);
        run_to(VBP + VV - 1, HBP + HV - 1);
        chk("last_vis", 32'(visible), 1);
        chk("last_px_x", 32'(px_x), HV - 1);
        chk("last_px_y", 32'(px_y), VV - 1);
        run_to(VBP + VV - 1, HBP + HV);
        chk("post_vis", 32'(visible), 0);
        chk("post_px_x", 32'(px_x), 0);
        run_to(VBP + VV, HBP);
        chk("vblank_vis", 32'(visible), 0);

        // one short line while locked
        short_l = 7;
        run_to(8, 0);
        chk("short_err", 32'(err), 1);
        chk("short_locked", 32'(locked), 0);
        chk("short_line_len", 32'(line_len), HT - 1);
        step();
        chk("short_err_pulse", 32'(err), 0);
        short_l = -1;
        run_to(0, 0);
        chk("short_relock_a", 32'(locked), 0);
        run_to(0, 0);
        chk("short_relock_b", 32'(locked), 0);
        run_to(0, 0);
        chk("short_relock_c", 32'(locked), 1);

        // h_sync stalls: h_cnt saturates from 30 to 2047
        run_to(4, 30);
        first_err = 0;
        err_cnt   = 0;
        for (int j = 1; j <= 2100; j++) begin
            h_sync = 1'b1;
            v_sync = 1'b1;
            @(posedge clk);
            #1;
            if (err) begin
                err_cnt++;
                if (first_err == 0)
                    first_err = j;
            end
        end
        chk("tmo_err_at", 32'(first_err), 2047 - 30 + 1);
        chk("tmo_err_cnt", 32'(err_cnt), 1);
        chk("tmo_locked", 32'(locked), 0);
        chk("tmo_visible", 32'(visible), 0);
        run_to(0, 0);
        chk("tmo_b1", 32'(locked), 0);
        run_to(0, 0);
        chk("tmo_b2", 32'(locked), 0);
        run_to(0, 0);
        chk("tmo_b3", 32'(locked), 1);

        // v_sync seven lines wide
        vsl = 7;
        run_to(7, 0);
        chk("wide_vsync_lines", 32'(vsync_lines), 7);
        chk("wide_still_locked", 32'(locked), 1);
        vsl = VS;
        run_to(0, 0);
        chk("wide_err", 32'(err), 1);
        chk("wide_locked", 32'(locked), 0);
        step();
        chk("wide_err_pulse", 32'(err), 0);
        run_to(0, 0);
        run_to(0, 0);
        chk("wide_relock", 32'(locked), 1);

        // asynchronous reset in the middle of a visible line
        run_to(6, 25);
        chk("pre_rst_vis", 32'(visible), 1);
        chk("pre_rst_px_x", 32'(px_x), 5);
        chk("pre_rst_px_y", 32'(px_y), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_visible", 32'(visible), 0);
        chk("arst_locked", 32'(locked), 0);
        chk("arst_px_x", 32'(px_x), 0);
        chk("arst_line_len", 32'(line_len), 0);
        chk("arst_hsync_len", 32'(hsync_len), 0);
        chk("arst_frame_lines", 32'(frame_lines), 0);
        chk("arst_vsync_lines", 32'(vsync_lines), 0);
        run_to(8, 40);
        rst_n = 1'b1;
        run_to(0, 0);
        chk("rst_b1", 32'(locked), 0);
        run_to(0, 0);
        chk("rst_b2", 32'(locked), 0);
        run_to(0, 0);
        chk("rst_b3", 32'(locked), 1);
        chk("rst_b3_line_len", 32'(line_len), HT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
